// File: rtl/sw_debounce_pkg.sv
// Shared types and default constants for the sw_debounce switch conditioner.
package sw_debounce_pkg;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } db_state_t;

   localparam int unsigned DEF_TICK_DIV   = 50000;
   localparam int unsigned DEF_STABLE_CNT = 4;

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounce channel: 2-flop synchronizer, STABLE/PENDING FSM with tick counter,
// and (with SW_DEBOUNCE_EDGE_EN) registered rise/fall pulses.
module debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic sw_raw,
`ifdef SW_DEBOUNCE_EDGE_EN
   output logic rise,
   output logic fall,
   output logic accept,
`endif
   output logic sw
);

   localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);

   logic             sync1;
   logic             sync2;
   db_state_t        state;
   logic [CNT_W-1:0] count;
   logic             differs;
   logic             full;

   assign differs = (sync2 != sw);
   assign full    = (count == CNT_W'(STABLE_CNT));

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= ST_STABLE;
         count <= '0;
         sw    <= 1'b0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
         if (tick) begin
            case (state)
               ST_STABLE: begin
                  if (differs) begin
                     state <= ST_PENDING;
                     count <= CNT_W'(1);
                  end
               end
               ST_PENDING: begin
                  if (!differs) begin
                     state <= ST_STABLE;
                     count <= '0;
                  end else if (full) begin
                     state <= ST_STABLE;
                     count <= '0;
                     sw    <= ~sw;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
               default: begin
                  state <= ST_STABLE;
                  count <= '0;
               end
            endcase
         end
      end
   end

`ifdef SW_DEBOUNCE_EDGE_EN
   // accept is the same-cycle condition that flips sw; edges register alongside it
   assign accept = tick && (state == ST_PENDING) && differs && full;

   always_ff @(posedge clk) begin
      if (rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= accept && !sw;
         fall <= accept && sw;
      end
   end
`endif

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: shared sample-tick divider plus WIDTH debounce_bit channels.
// Edge outputs are built only when SW_DEBOUNCE_EDGE_EN is defined; otherwise tied to 0.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
   parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             changed
);

   localparam int unsigned DIV_W = $clog2(TICK_DIV);

   logic [DIV_W-1:0] div;
   logic             tick;

   assign tick = (div == DIV_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + DIV_W'(1);
      end
   end

`ifdef SW_DEBOUNCE_EDGE_EN
   logic [WIDTH-1:0] accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         changed <= 1'b0;
      end else begin
         changed <= |accept;
      end
   end
`else
   assign sw_rise = '0;
   assign sw_fall = '0;
   assign changed = 1'b0;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_bit #(
         .STABLE_CNT(STABLE_CNT)
      ) u_bit (
         .clk    (clk),
         .rst    (rst),
         .tick   (tick),
         .sw_raw (sw_raw[i]),
`ifdef SW_DEBOUNCE_EDGE_EN
         .rise   (sw_rise[i]),
         .fall   (sw_fall[i]),
         .accept (accept[i]),
`endif
         .sw     (sw[i])
      );
   end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce (TICK_DIV=4, STABLE_CNT=3) against a run-length reference model.
`timescale 1ns/1ps
module tb_sw_debounce;

   localparam int W  = 16;
   localparam int TD = 4;
   localparam int SC = 3;
`ifdef SW_DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] sw_raw = '0;
   logic [W-1:0] sw, sw_rise, sw_fall;
   logic         changed;

   int checks = 0;
   int errors = 0;

   sw_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
      .clk(clk), .rst(rst), .sw_raw(sw_raw),
      .sw(sw), .sw_rise(sw_rise), .sw_fall(sw_fall), .changed(changed)
   );

   always #5 clk = ~clk;

   // Reference: raw seen through a 2-cycle delay, sampled every TD-th cycle since reset;
   // a bit flips once its sampled value has differed on SC+1 consecutive samples.
   logic [W-1:0] m_s1, m_s2, m_sw, e_rise, e_fall;
   logic         e_changed;
   int           m_cyc;
   int           m_run [W];

   always @(posedge clk) begin
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_sw = '0; e_rise = '0; e_fall = '0; e_changed = 1'b0;
         m_cyc = 0;
         for (int b = 0; b < W; b++) m_run[b] = 0;
      end else begin
         e_rise = '0;
         e_fall = '0;
         if ((m_cyc % TD) == TD - 1) begin
            for (int b = 0; b < W; b++) begin
               if (m_s2[b] != m_sw[b]) begin
                  m_run[b]++;
                  if (m_run[b] == SC + 1) begin
                     m_sw[b] = ~m_sw[b];
                     m_run[b] = 0;
                     if (EDGE_EN) begin
                        if (m_sw[b]) e_rise[b] = 1'b1;
                        else         e_fall[b] = 1'b1;
                     end
                  end
               end else begin
                  m_run[b] = 0;
               end
            end
         end
         e_changed = |(e_rise | e_fall);
         m_cyc++;
         m_s2 = m_s1;
         m_s1 = sw_raw;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sw_raw = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sw_raw = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({sw, sw_rise, sw_fall, changed} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got sw=%h rise=%h fall=%h chg=%b, want all 0",
                  sw, sw_rise, sw_fall, changed);
      end
      rst = 1'b0;
   endtask

   task automatic test_raw_step();
      int first_sw = -1;
      int rise_n = 0;
      int chg_bad = 0;
      sw_raw[0] = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         checks++;
         if ({sw, sw_rise, sw_fall, changed} !== {m_sw, e_rise, e_fall, e_changed}) begin
            errors++;
            $display("FAIL step_model c=%0d: got sw=%h rise=%h fall=%h chg=%b, want %h %h %h %b",
                     c, sw, sw_rise, sw_fall, changed, m_sw, e_rise, e_fall, e_changed);
         end
         if (sw[0] === 1'b1 && first_sw < 0) first_sw = c;
         if (sw_rise[0] === 1'b1) rise_n++;
         if (changed !== (EDGE_EN && sw_rise[0] === 1'b1)) chg_bad++;
      end
      checks++;
      if (first_sw < 1 || first_sw > 19) begin
         errors++;
         $display("FAIL step_latency: got %0d cycles, want 1..19", first_sw);
      end
      checks++;
      if (rise_n != (EDGE_EN ? 1 : 0)) begin
         errors++;
         $display("FAIL step_rise_width: got %0d cycles, want %0d", rise_n, EDGE_EN ? 1 : 0);
      end
      checks++;
      if (chg_bad != 0) begin
         errors++;
         $display("FAIL step_changed: got %0d non-coincident cycles, want 0", chg_bad);
      end
   endtask

   task automatic test_glitch();
      int bad = 0;
      sw_raw[5] = 1'b1;
      repeat (6) @(negedge clk);
      sw_raw[5] = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (sw[5] !== 1'b0 || sw_rise[5] !== 1'b0) bad++;
         checks++;
         if ({sw, sw_rise, sw_fall, changed} !== {m_sw, e_rise, e_fall, e_changed}) begin
            errors++;
            $display("FAIL glitch_model c=%0d: got sw=%h rise=%h, want %h %h", c, sw, sw_rise, m_sw, e_rise);
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL glitch_reject: got %0d cycles with sw[5]/rise[5] high, want 0", bad);
      end
   endtask

   task automatic test_simultaneous();
      logic [W-1:0] first_val = '0;
      logic [W-1:0] rise_at = '0;
      int first_c = -1;
      int rise_n = 0;
      do_reset();
      repeat (2) @(negedge clk);
      sw_raw = 16'hC00F;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (sw !== '0 && first_c < 0) begin
            first_c = c;
            first_val = sw;
            rise_at = sw_rise;
         end
         if (sw_rise !== '0) rise_n++;
         checks++;
         if ({sw, sw_rise, sw_fall, changed} !== {m_sw, e_rise, e_fall, e_changed}) begin
            errors++;
            $display("FAIL simul_model c=%0d: got sw=%h rise=%h, want %h %h", c, sw, sw_rise, m_sw, e_rise);
         end
      end
      checks++;
      if (first_val !== 16'hC00F) begin
         errors++;
         $display("FAIL simul_sw: got %h on first change, want c00f", first_val);
      end
      checks++;
      if (rise_at !== (EDGE_EN ? 16'hC00F : 16'h0000) || rise_n != (EDGE_EN ? 1 : 0)) begin
         errors++;
         $display("FAIL simul_rise: got %h over %0d cycles, want %h over %0d",
                  rise_at, rise_n, EDGE_EN ? 16'hC00F : 16'h0000, EDGE_EN ? 1 : 0);
      end
   endtask

   task automatic test_release();
      int fall_n = 0;
      int rise_n = 0;
      sw_raw = 16'h400F;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (sw_fall[15] === 1'b1) fall_n++;
         if (sw_rise !== '0) rise_n++;
         checks++;
         if ({sw, sw_rise, sw_fall, changed} !== {m_sw, e_rise, e_fall, e_changed}) begin
            errors++;
            $display("FAIL release_model c=%0d: got sw=%h fall=%h, want %h %h", c, sw, sw_fall, m_sw, e_fall);
         end
      end
      checks++;
      if (sw !== 16'h400F) begin
         errors++;
         $display("FAIL release_sw: got %h, want 400f", sw);
      end
      checks++;
      if (fall_n != (EDGE_EN ? 1 : 0) || rise_n != 0) begin
         errors++;
         $display("FAIL release_edges: got fall=%0d rise=%0d cycles, want %0d and 0",
                  fall_n, rise_n, EDGE_EN ? 1 : 0);
      end
   endtask

   task automatic test_reset_mid_pending();
      int waited = 0;
      int first_c = -1;
      int rise_c = -1;
      do_reset();
      repeat (2) @(negedge clk);
      sw_raw[3] = 1'b1;
      while (m_run[3] != 2 && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (m_run[3] != 2) begin
         errors++;
         $display("FAIL midpend_setup: got run %0d after %0d cycles, want 2", m_run[3], waited);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({sw, sw_rise, sw_fall, changed} !== '0) begin
         errors++;
         $display("FAIL midpend_clear: got sw=%h rise=%h fall=%h chg=%b, want all 0",
                  sw, sw_rise, sw_fall, changed);
      end
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (sw[3] === 1'b1 && first_c < 0) first_c = c;
         if (sw_rise[3] === 1'b1 && rise_c < 0) rise_c = c;
      end
      checks++;
      if (first_c != 16) begin
         errors++;
         $display("FAIL midpend_latency: got sw[3] after %0d cycles, want 16", first_c);
      end
      checks++;
      if (rise_c != (EDGE_EN ? 16 : -1)) begin
         errors++;
         $display("FAIL midpend_rise: got rise[3] at %0d, want %0d", rise_c, EDGE_EN ? 16 : -1);
      end
   endtask

   task automatic test_random();
      int hold = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         checks++;
         if ({sw, sw_rise, sw_fall, changed} !== {m_sw, e_rise, e_fall, e_changed}) begin
            errors++;
            $display("FAIL random_model c=%0d: got sw=%h rise=%h fall=%h chg=%b, want %h %h %h %b",
                     c, sw, sw_rise, sw_fall, changed, m_sw, e_rise, e_fall, e_changed);
         end
         rst = ($urandom_range(0, 399) == 0);
         if (hold == 0) begin
            sw_raw = sw_raw ^ (W'($urandom) & W'($urandom) & W'($urandom));
            hold = $urandom_range(1, 24);
         end else begin
            hold--;
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_raw_step();
      test_glitch();
      test_simultaneous();
      test_release();
      test_reset_mid_pending();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
